serial_subtractor16: RTL and testbench
======================================

Name: serial_subtractor16

Overview:
- Multi-cycle, bit-serial two's-complement subtractor. Computes diff = a - b - bin, LSB first, one bit per clock.
- Uses a start/busy/done handshake.
- Complements the combinational ripple adder. Gives the lab datapath a low-area subtract path with borrow-out and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 2).
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured at the accepting edge.
- b  input  WIDTH  subtrahend; captured at the accepting edge.
- bin  input  1  borrow-in; captured at the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- diff  output  WIDTH  a - b - bin, modulo 2**WIDTH.
- bout  output  1  borrow out; 1 iff unsigned a < b + bin.
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n). Reset is fixed, not configurable.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0. Internal shift registers, borrow and counter are also cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b and bin into shift/borrow registers, clears cnt, sets busy=1 and moves to RUN. start=0 stays in IDLE.
- RUN: at each edge:
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw' = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Shift d into the result register from the MSB side, shift both operands right, cnt++.
- RUN exit: on the edge that processes bit WIDTH-1:
  - move to DONE.
  - diff takes the full result; bout = final borrow.
  - ovf = borrow into MSB XOR borrow out of MSB.
  - busy=0, done=1.
- Latency: done rises exactly WIDTH edges after the accepting edge (16 for the default). busy is high for exactly WIDTH cycles.
- DONE: lasts one cycle. done drops and the state returns to IDLE on the next edge. start is ignored in DONE, so the earliest next accept is one cycle after done.
- Hold rules:
  - start during RUN or DONE is ignored; operands are not re-sampled.
  - Changes to a, b or bin after acceptance have no effect.
  - diff, bout and ovf change only on the done edge and otherwise hold their last value, including while idle.
- Reset mid-operation: rst_n low at any time forces the reset values immediately, without waiting for a clock edge. The aborted operation never asserts done. After rst_n is released, the next start runs normally.
- Wrap-around: the result is modulo 2**WIDTH. There are no saturation modes.

Decomposition:
- Shared package serial_sub_pkg:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default WIDTH/CNT_W constants.
- Sub-module full_sub1 (combinational 1-bit full subtractor):
  - inputs x, y, bi; outputs d, bo.
  - Instantiated once in the datapath. Verify it alone exhaustively (8 vectors).

Test Plan:
- a=0xFF00, b=0x00FF, bin=0, pulse start -> after 16 clocks done=1 for one cycle; diff=0xFE01, bout=0, ovf=0; busy high exactly 16 cycles.
- a=0xFF00, b=0x00FF, bin=1 -> diff=0xFE00, bout=0, ovf=0. a=0x03C3, b=0x00CF, bin=1 -> diff=0x02F3, bout=0, ovf=0.
- Borrow and overflow:
  - a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0.
  - a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
  - a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- Ignored inputs:
  - Hold start high continuously and change a/b mid-RUN -> the first result matches the captured operands.
  - Operations start only from IDLE; each done is followed by at least one non-busy cycle.
- Reset mid-operation:
  - Start 0x1234-0x0034, then pull rst_n low after 8 clocks -> busy=0, done=0, diff=0 immediately (asynchronously); no done pulse follows.
  - Release reset and start 0x1234-0x0034 -> diff=0x1200 after 16 clocks.
- Results stay stable when idle: after a completed operation, toggle a/b/bin with start=0 for 20 cycles -> diff/bout/ovf unchanged, done stays 0.

Source files
------------

// File: rtl/serial_subtractor16_pkg.sv
// serial_sub_pkg: shared FSM encodings and default sizes for the bit-serial subtractor
package serial_sub_pkg;
  localparam int WIDTH_D = 16;
  localparam int CNT_W_D = 5;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_subtractor16_if.sv
// serial_subtractor16_if: start/busy/done handshake plus operand and result buses
interface serial_subtractor16_if #(parameter int WIDTH = serial_sub_pkg::WIDTH_D);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic bout;
  logic ovf;
  modport master(output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave(input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor16_full_sub1.sv
// full_sub1: combinational 1-bit full subtractor, d = x - y - bi
module full_sub1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor16.sv
// serial_subtractor16: bit-serial a - b - bin, LSB first, with borrow-out and signed overflow
module serial_subtractor16
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor16_if.slave bus
);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CNT_W-1:0] cnt;
  logic brw, d, bo, last;
  full_sub1 u_fs (.x(a_sh[0]), .y(b_sh[0]), .bi(brw), .d(d), .bo(bo));
  assign last = cnt == CNT_W'(WIDTH - 1);
  always_comb begin
    state_nx = (state == ST_IDLE) ? (bus.start ? ST_RUN : ST_IDLE) :
               (state == ST_RUN)  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
    bus.busy = state == ST_RUN;
    bus.done = state == ST_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      brw  <= bus.bin;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      res  <= {d, res[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      brw  <= bo;
      cnt  <= cnt + 1'b1;
      // brw still holds the borrow into the MSB while the MSB is processed
      if (last) begin
        bus.diff <= {d, res[WIDTH-1:1]};
        bus.bout <= bo;
        bus.ovf  <= brw ^ bo;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor16.sv
// tb_serial_subtractor16: directed checks of the serial subtractor and its 1-bit cell
module tb_serial_subtractor16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  serial_subtractor16_if #(.WIDTH(16)) bus ();
  serial_subtractor16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic fx, fy, fbi, fd, fbo;
  full_sub1 u_cell (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        output int cyc, output int busy_cnt);
    @(negedge clk);
    bus.a = ia;
    bus.b = ib;
    bus.bin = ibin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, busy_cnt);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.ovf} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_values busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.diff, bus.bout, bus.ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_sub1();
    logic [7:0] exp_d, exp_bo;
    exp_d  = 8'b10010110;
    exp_bo = 8'b10001110;
    for (int i = 0; i < 8; i++) begin
      {fx, fy, fbi} = 3'(i);
      #1;
      vectors++;
      if ({fd, fbo} !== {exp_d[i], exp_bo[i]}) begin
        miscompares++;
        $display("FAIL full_sub1[%0d] d=%b bo=%b want d=%b bo=%b", i, fd, fbo, exp_d[i], exp_bo[i]);
      end
    end
  endtask

  task automatic test_vectors();
    vec_t tv[6];
    int cyc, busy_cnt;
    tv[0] = '{16'hFF00, 16'h00FF, 1'b0, 16'hFE01, 1'b0, 1'b0};
    tv[1] = '{16'hFF00, 16'h00FF, 1'b1, 16'hFE00, 1'b0, 1'b0};
    tv[2] = '{16'h03C3, 16'h00CF, 1'b1, 16'h02F3, 1'b0, 1'b0};
    tv[3] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tv[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    foreach (tv[i]) begin
      run_op(tv[i].a, tv[i].b, tv[i].bin, cyc, busy_cnt);
      vectors++;
      if (cyc !== 16 || busy_cnt !== 16) begin
        miscompares++;
        $display("FAIL latency[%0d] done_after=%0d busy_cycles=%0d want 16/16", i, cyc, busy_cnt);
      end
      vectors++;
      if ({bus.diff, bus.bout, bus.ovf} !== {tv[i].diff, tv[i].bout, tv[i].ovf}) begin
        miscompares++;
        $display("FAIL result[%0d] diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b", i,
                 bus.diff, bus.bout, bus.ovf, tv[i].diff, tv[i].bout, tv[i].ovf);
      end
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL done_pulse[%0d] done=%b busy=%b want 0/0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_hold_start();
    int cyc, busy_cnt;
    @(negedge clk);
    bus.a = 16'h1111;
    bus.b = 16'h0022;
    bus.bin = 1'b0;
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    bus.a = 16'h5555;
    bus.b = 16'h1111;
    wait_done(cyc, busy_cnt);
    vectors++;
    if ({bus.done, bus.diff, bus.bout, bus.ovf} !== {1'b1, 16'h10EF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_first done=%b diff=%h bout=%b ovf=%b want 1 10ef 0 0",
               bus.done, bus.diff, bus.bout, bus.ovf);
    end
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_gap busy=%b want 0", bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_restart busy=%b want 1", bus.busy);
    end
    bus.start = 1'b0;
    wait_done(cyc, busy_cnt);
    vectors++;
    if ({bus.done, bus.diff} !== {1'b1, 16'h4444}) begin
      miscompares++;
      $display("FAIL hold_second done=%b diff=%h want 1 4444", bus.done, bus.diff);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, busy_cnt, seen;
    @(negedge clk);
    bus.a = 16'h1234;
    bus.b = 16'h0034;
    bus.bin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.diff} !== 18'd0) begin
      miscompares++;
      $display("FAIL async_reset busy=%b done=%b diff=%h want 0 0 0", bus.busy, bus.done, bus.diff);
    end
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (bus.done) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL aborted_done pulses=%0d want 0", seen);
    end
    run_op(16'h1234, 16'h0034, 1'b0, cyc, busy_cnt);
    vectors++;
    if ({cyc, bus.diff, bus.bout, bus.ovf} !== {32'd16, 16'h1200, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL post_reset cyc=%0d diff=%h bout=%b ovf=%b want 16 1200 0 0",
               cyc, bus.diff, bus.bout, bus.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_idle_stable();
    for (int i = 0; i < 20; i++) begin
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.bin = 1'($urandom);
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.busy, bus.diff, bus.bout, bus.ovf} !== {2'b00, 16'h1200, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL idle_stable[%0d] done=%b busy=%b diff=%h bout=%b ovf=%b want 0 0 1200 0 0",
                 i, bus.done, bus.busy, bus.diff, bus.bout, bus.ovf);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    {fx, fy, fbi} = 3'b000;
    test_reset();
    test_full_sub1();
    test_vectors();
    test_hold_start();
    test_reset_mid();
    test_idle_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
